dmem_responder: RTL

//  Data-memory responder on the CPU's ram_* port. The CPU is the initiator; this block serves it.

---
 rtl/dmem_responder.sv | 96 +++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data RAM responder with byte lanes, access counters and an optional
// LED register mapped at the all-ones word address (enabled by DMEM_LED_MMIO_EN)
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_req,
    input  logic              ram_rw,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [3:0]        ram_sel,
    input  logic [31:0]       ram_data_in,
    output logic [31:0]       ram_data_out,
    output logic              ram_ready,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic [31:0]       led_data_out
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0] sel_q;
    logic [31:0] data_q;
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic accept, done, led_hit;
    logic [31:0] mask, rd_word;
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done    = 1'b0;
        if (state == IDLE && ram_req) begin
            state_n = WAIT;
            accept  = 1'b1;
        end else if (state == WAIT && cnt == 4'd0) begin
            state_n = IDLE;
            done    = 1'b1;
        end
    end
    assign mask    = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
    assign rd_word = (led_hit ? led_data_out : mem[addr_q]) & mask;
    // Only the copy latched at accept is used; the live inputs may change freely afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            sel_q        <= '0;
            data_q       <= '0;
            ram_data_out <= '0;
            ram_ready    <= 1'b0;
            rd_count     <= '0;
            wr_count     <= '0;
        end else begin
            state     <= state_n;
            ram_ready <= done;
            if (accept) begin
                rw_q   <= ram_rw;
                addr_q <= ram_addr;
                sel_q  <= ram_sel;
                data_q <= ram_data_in;
                cnt    <= 4'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (done && rw_q) wr_count <= wr_count + 32'd1;
            if (done && !rw_q) begin
                rd_count     <= rd_count + 32'd1;
                ram_data_out <= rd_word;
            end
        end
    end
    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (done && rw_q && !led_hit)
            for (int i = 0; i < 4; i++)
                if (sel_q[i]) mem[addr_q][8*i +: 8] <= data_q[8*i +: 8];
    end
`ifdef DMEM_LED_MMIO_EN
    assign led_hit = &addr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_data_out <= '0;
        end else if (done && rw_q && led_hit) begin
            for (int i = 0; i < 4; i++)
                if (sel_q[i]) led_data_out[8*i +: 8] <= data_q[8*i +: 8];
        end
    end
`else
    assign led_hit      = 1'b0;
    assign led_data_out = '0;
`endif
endmodule
